// File: rtl/zigzag_buffer.sv
// rtl/zigzag_buffer.sv - double-buffered 8x8 raster-to-zigzag reorder stage
// Rows land in raster order; words are gathered through the JPEG zigzag table on read.
module zigzag_buffer #(
    parameter int COEF_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*COEF_W-1:0]   in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [8*COEF_W-1:0]   out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last
);

    localparam int DW = 8 * COEF_W;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [COEF_W-1:0] r_bank0 [64];
    logic [COEF_W-1:0] r_bank1 [64];
    logic [1:0]        r_full;
    logic              r_wb;
    logic              r_rb;
    logic [2:0]        r_wr_row;
    logic [2:0]        r_rd_word;

    logic              w_wr;
    logic              w_rd;
    logic              w_wr_done;
    logic              w_rd_done;
    logic [1:0]        w_full_nxt;
    logic              w_out_valid;
    logic [DW-1:0]     w_out;

    assign in_ready    = reset && !r_full[r_wb];
    assign w_out_valid = r_full[r_rb];
    assign w_wr        = in_valid && in_ready;
    assign w_rd        = w_out_valid && out_ready;
    assign w_wr_done   = w_wr && (r_wr_row == 3'd7);
    assign w_rd_done   = w_rd && (r_rd_word == 3'd7);

    // Set and clear target different banks, so both may land in one cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_done) w_full_nxt[r_rb] = 1'b0;
        if (w_wr_done) w_full_nxt[r_wb] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full    <= 2'b00;
            r_wb      <= 1'b0;
            r_rb      <= 1'b0;
            r_wr_row  <= 3'd0;
            r_rd_word <= 3'd0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr) begin
                r_wr_row <= r_wr_row + 3'd1;
                if (w_wr_done) r_wb <= ~r_wb;
            end
            if (w_rd) begin
                r_rd_word <= r_rd_word + 3'd1;
                if (w_rd_done) r_rb <= ~r_rb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int c = 0; c < 8; c++) begin
                if (r_wb) r_bank1[{r_wr_row, 3'(c)}] <= in[DW-1-c*COEF_W -: COEF_W];
                else      r_bank0[{r_wr_row, 3'(c)}] <= in[DW-1-c*COEF_W -: COEF_W];
            end
        end
    end

    always_comb begin
        w_out = '0;
        if (w_out_valid) begin
            for (int p = 0; p < 8; p++) begin
                w_out[DW-1-p*COEF_W -: COEF_W] = r_rb ? r_bank1[ZZ[{r_rd_word, 3'(p)}]]
                                                      : r_bank0[ZZ[{r_rd_word, 3'(p)}]];
            end
        end
    end

    assign out       = w_out;
    assign out_valid = w_out_valid;
    assign out_first = w_out_valid && (r_rd_word == 3'd0);
    assign out_last  = w_out_valid && (r_rd_word == 3'd7);

endmodule

// File: tb/tb_zigzag_buffer.sv
// tb/tb_zigzag_buffer.sv - randomized bench for zigzag_buffer against a block-level model
module tb_zigzag_buffer;

    localparam int W  = 10;
    localparam int DW = 8 * W;

    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] din = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dout;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_first;
    logic          out_last;

    zigzag_buffer #(.COEF_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: completed blocks become a FIFO of expected zigzag words.
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] rows [8];
    int            n_rows = 0;
    bit            mon_en = 1'b0;

    function automatic logic [DW-1:0] zz_word(input int w);
        logic [DW-1:0] res;
        logic [DW-1:0] row;
        int idx;
        res = '0;
        for (int p = 0; p < 8; p++) begin
            idx = ZZ[8*w+p];
            row = rows[idx/8];
            res[DW-1-p*W -: W] = row[DW-1-(idx%8)*W -: W];
        end
        return res;
    endfunction

    always @(negedge clk) begin : monitor
        int            sz;
        bit            ev;
        bit            er;
        logic [DW-1:0] eo;
        if (mon_en) begin
            sz = exp_q.size();
            ev = (sz > 0);
            er = reset && (sz <= 8);
            eo = ev ? exp_q[0] : '0;
            check_eq("in_ready",  DW'(in_ready),  DW'(er));
            check_eq("out_valid", DW'(out_valid), DW'(ev));
            check_eq("out_data",  dout,           eo);
            check_eq("out_first", DW'(out_first), DW'(ev && (sz % 8 == 0)));
            check_eq("out_last",  DW'(out_last),  DW'(ev && (sz % 8 == 1)));
            if (!reset) begin
                exp_q.delete();
                n_rows = 0;
            end else begin
                if (ev && out_ready) void'(exp_q.pop_front());
                if (er && in_valid) begin
                    rows[n_rows] = din;
                    n_rows++;
                    if (n_rows == 8) begin
                        for (int w = 0; w < 8; w++) exp_q.push_back(zz_word(w));
                        n_rows = 0;
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [DW-1:0] d);
        int t;
        bit acc;
        t   = 0;
        acc = 1'b0;
        din = d;
        in_valid = 1'b1;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = in_ready && reset;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        check_eq("row_accept", DW'(acc), DW'(1'b1));
    endtask

    function automatic logic [DW-1:0] rand_row();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    bit feed_done = 1'b0;

    initial begin
        logic [DW-1:0] r;
        int t;

        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cycles(3);
        reset = 1'b1;

        // Ramp block 8r+c
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 8; c++) r[DW-1-c*W -: W] = W'(8*i + c);
            send_row(r);
        end
        cycles(12);

        // Three back-to-back random blocks
        for (int i = 0; i < 24; i++) send_row(rand_row());
        cycles(12);

        // Both banks fill under backpressure
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) send_row(rand_row());
            end
            begin
                cycles(40);
                out_ready = 1'b1;
            end
        join
        cycles(20);

        // Sign preservation: alternating -1 / -512
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 8; c++) r[DW-1-c*W -: W] = ((8*i + c) % 2 == 0) ? 10'h3FF : 10'h200;
            send_row(r);
        end
        cycles(12);

        // Mid-block reset discards the partial block
        for (int i = 0; i < 5; i++) send_row(rand_row());
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) send_row(rand_row());
        cycles(12);

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 240; i++) begin
                    cycles($urandom_range(0, 2));
                    send_row(rand_row());
                end
                feed_done = 1'b1;
            end
            begin
                while (!feed_done) begin
                    out_ready = $urandom_range(0, 1) == 1;
                    cycles(1);
                end
                out_ready = 1'b1;
            end
        join

        t = 0;
        while (out_valid && t < 100) begin
            cycles(1);
            t++;
        end
        check_eq("drain_valid", DW'(out_valid), DW'(1'b0));
        check_eq("drain_model", DW'(exp_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
